oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 148 ++++++++++++++
 tb/tb_oam_dma.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to the DMA register copies XFER_LEN bytes from page
// {src_page, 00} to OAM_BASE through an initiator bus with a ready handshake.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int unsigned XFER_LEN     = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_hit,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wdata,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [7:0]  m_rdata,
  input  logic        m_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);

  state_t      state, state_nxt;
  logic [7:0]  idx, idx_nxt;
  logic [7:0]  page_reg, page_nxt;
  logic        pending, pending_nxt;
  logic [15:0] m_addr_nxt;
  logic [7:0]  m_wdata_nxt;
  logic        m_rd_nxt, m_wr_nxt, busy_nxt, done_nxt;
  logic [7:0]  cpu_rdata_nxt;
  logic        cpu_hit_nxt;
  logic        reg_wr, restart, go;
  logic [7:0]  src_page;

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    page_nxt      = page_reg;
    pending_nxt   = pending;
    m_addr_nxt    = m_addr;
    m_wdata_nxt   = m_wdata;
    m_rd_nxt      = m_rd;
    m_wr_nxt      = m_wr;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    go            = 1'b0;

    reg_wr = cpu_wr && (cpu_addr == DMA_REG_ADDR);
    if (reg_wr) page_nxt = cpu_wdata;
    // Echo RAM E000-FFFF folds onto C000-DFFF.
    src_page = (page_nxt < 8'hE0) ? page_nxt : page_nxt - 8'h20;
    // A restart written in the same cycle as m_ready takes effect at once.
    restart  = reg_wr || pending;

    cpu_hit_nxt   = cpu_rd && (cpu_addr == DMA_REG_ADDR);
    cpu_rdata_nxt = cpu_hit_nxt ? page_reg : '0;

    unique case (state)
      IDLE: begin
        if (reg_wr) go = 1'b1;
      end
      READ: begin
        if (m_ready) begin
          if (restart) begin
            go = 1'b1;
          end else begin
            state_nxt   = WRITE;
            m_rd_nxt    = 1'b0;
            m_wr_nxt    = 1'b1;
            m_addr_nxt  = OAM_BASE + {8'h00, idx};
            m_wdata_nxt = m_rdata;
          end
        end else if (reg_wr) begin
          pending_nxt = 1'b1;
        end
      end
      WRITE: begin
        if (m_ready) begin
          if (restart) begin
            go = 1'b1;
          end else if (idx == LAST) begin
            state_nxt = IDLE;
            m_wr_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt  = READ;
            idx_nxt    = idx + 8'd1;
            m_wr_nxt   = 1'b0;
            m_rd_nxt   = 1'b1;
            m_addr_nxt = {src_page, idx + 8'd1};
          end
        end else if (reg_wr) begin
          pending_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (go) begin
      state_nxt   = READ;
      idx_nxt     = '0;
      pending_nxt = 1'b0;
      m_rd_nxt    = 1'b1;
      m_wr_nxt    = 1'b0;
      m_addr_nxt  = {src_page, 8'h00};
      busy_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      page_reg  <= '0;
      pending   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_rd      <= 1'b0;
      m_wr      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_rdata <= '0;
      cpu_hit   <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      page_reg  <= page_nxt;
      pending   <= pending_nxt;
      m_addr    <= m_addr_nxt;
      m_wdata   <= m_wdata_nxt;
      m_rd      <= m_rd_nxt;
      m_wr      <= m_wr_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      cpu_hit   <= cpu_hit_nxt;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a bus responder with optional stalls logs every
// completed read/write; the main sequence checks transfers against hand values.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr, cpu_rd;
  logic [7:0]  cpu_rdata;
  logic        cpu_hit;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_rd, m_wr;
  logic [7:0]  m_rdata;
  logic        m_ready;
  logic        busy, done;

  oam_dma #(.DMA_REG_ADDR(16'hFF46), .OAM_BASE(16'hFE00), .XFER_LEN(160)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[15:8];
    return (a[7:0] ^ 8'h5C) + (hi * 8'd3);
  endfunction

  // responder / monitor state
  bit          rnd_mode = 1'b0;
  bit          hold_en  = 1'b0;
  logic [15:0] hold_addr = '0;
  bit          at_hold  = 1'b0;
  bit          in_phase = 1'b0;
  int          stall    = 0;
  logic [15:0] cap_addr;
  logic [7:0]  cap_wdata;
  logic        cap_rd, cap_wr;
  logic [15:0] rd_log[$];
  logic [15:0] wr_log[$];
  logic [7:0]  oam [0:255];
  int          done_cnt = 0;
  bit          first_seen = 1'b0;
  int unsigned first_rd_cyc = 0, done_cyc = 0;
  int          stab_err = 0, bus_err = 0, req_seen = 0;

  initial begin
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      m_rdata = src_byte(m_addr);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (m_rd && m_wr) bus_err++;
      if ((m_rd || m_wr) && !busy) bus_err++;
      if (m_rd || m_wr) req_seen++;
      if (m_rd && !first_seen) begin first_seen = 1'b1; first_rd_cyc = cyc; end
      if (reset) begin
        in_phase = 1'b0;
        m_ready  = 1'b0;
      end else if (m_rd || m_wr) begin
        if (!in_phase) begin
          in_phase = 1'b1;
          cap_addr = m_addr; cap_wdata = m_wdata; cap_rd = m_rd; cap_wr = m_wr;
          stall = rnd_mode ? int'($urandom_range(0, 5)) : 0;
          if (hold_en && m_rd && m_addr == hold_addr) begin
            stall = 4; hold_en = 1'b0; at_hold = 1'b1;
          end
        end else if (m_addr !== cap_addr || m_rd !== cap_rd || m_wr !== cap_wr ||
                     m_wdata !== cap_wdata) begin
          stab_err++;
        end
        if (stall > 0) begin
          m_ready = 1'b0;
          stall--;
        end else begin
          m_ready  = 1'b1;
          in_phase = 1'b0;
          if (m_rd) rd_log.push_back(m_addr);
          else begin
            wr_log.push_back(m_addr);
            oam[m_addr[7:0]] = m_wdata;
          end
        end
      end else begin
        in_phase = 1'b0;
        // m_ready toggles while idle; the DMA must ignore it
        m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    for (int i = 0; i < 256; i++) oam[i] = 'x;
    done_cnt = 0; first_seen = 1'b0; stab_err = 0; req_seen = 0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    @(negedge clk);
    cpu_addr = a; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
    check({tag, "_done_in_time"}, 32'(done_cnt != 0), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_xfer(input string tag, input logic [7:0] sp);
    int seq = 0, bad = 0;
    check({tag, "_nreads"}, rd_log.size(), 160);
    check({tag, "_nwrites"}, wr_log.size(), 160);
    check({tag, "_first_rd"}, rd_log.size() > 0 ? 32'(rd_log[0]) : 32'hFFFF_FFFF, {16'h0, sp, 8'h00});
    for (int i = 0; i < 160; i++) begin
      if (i >= rd_log.size() || rd_log[i] !== {sp, 8'(i)}) seq++;
      if (i >= wr_log.size() || wr_log[i] !== 16'hFE00 + 16'(i)) seq++;
      if (oam[i] !== src_byte({sp, 8'(i)})) bad++;
    end
    check({tag, "_addr_seq_errs"}, seq, 0);
    check({tag, "_oam_bad_bytes"}, bad, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_rd", m_rd, 0);
    check("rst_m_wr", m_wr, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cpu_hit", cpu_hit, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // writes elsewhere are ignored
    clear_logs();
    cpu_write(16'hFF45, 8'h77);
    repeat (3) @(negedge clk);
    check("other_addr_busy", busy, 0);
    check("other_addr_reqs", req_seen, 0);

    // register readback
    clear_logs();
    cpu_write(16'hFF46, 8'h5A);
    cpu_read(16'hFF46);
    check("rd_ff46_hit", cpu_hit, 1);
    check("rd_ff46_data", cpu_rdata, 8'h5A);
    cpu_read(16'hFF47);
    check("rd_ff47_hit", cpu_hit, 0);
    wait_done("p5A", 1000);
    check("p5A_done_pulses", done_cnt, 1);

    // full transfer, m_ready tied high
    clear_logs();
    cpu_write(16'hFF46, 8'hC1);
    check("c1_busy_start", busy, 1);
    check("c1_m_rd_start", m_rd, 1);
    check("c1_m_addr_start", m_addr, 16'hC100);
    wait_done("c1", 1000);
    check_xfer("c1", 8'hC1);
    check("c1_last_rd", rd_log.size() == 160 ? 32'(rd_log[159]) : 32'h0, 16'hC19F);
    check("c1_last_wr", wr_log.size() == 160 ? 32'(wr_log[159]) : 32'h0, 16'hFE9F);
    check("c1_done_latency", done_cyc - first_rd_cyc, 320);

    // echo fold and its boundary
    clear_logs();
    cpu_write(16'hFF46, 8'hE3);
    wait_done("e3", 1000);
    check_xfer("e3", 8'hC3);
    clear_logs();
    cpu_write(16'hFF46, 8'hDF);
    wait_done("df", 1000);
    check_xfer("df", 8'hDF);

    // random stalls
    clear_logs();
    rnd_mode = 1'b1;
    cpu_write(16'hFF46, 8'hC4);
    wait_done("rnd", 5000);
    rnd_mode = 1'b0;
    check_xfer("rnd", 8'hC4);
    check("rnd_stable", stab_err, 0);

    // restart while a read of idx 50 is stalled
    clear_logs();
    hold_addr = 16'h8032; hold_en = 1'b1; at_hold = 1'b0;
    cpu_write(16'hFF46, 8'h80);
    n = 0;
    while (!at_hold && n < 1000) begin @(negedge clk); n++; end
    check("rs_reached_idx50", 32'(at_hold), 1);
    cpu_write(16'hFF46, 8'h90);
    wait_done("rs", 1000);
    check("rs_nreads", rd_log.size(), 211);
    check("rs_nwrites", wr_log.size(), 210);
    check("rs_rd50", rd_log.size() > 51 ? 32'(rd_log[50]) : 32'h0, 16'h8032);
    check("rs_rd51", rd_log.size() > 51 ? 32'(rd_log[51]) : 32'h0, 16'h9000);
    check("rs_wr50", wr_log.size() > 50 ? 32'(wr_log[50]) : 32'h0, 16'hFE00);
    check("rs_done_pulses", done_cnt, 1);
    check("rs_stable", stab_err, 0);
    n = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== src_byte({8'h90, 8'(i)})) n++;
    check("rs_oam_bad_bytes", n, 0);

    // asynchronous reset during the write of idx 77
    clear_logs();
    cpu_write(16'hFF46, 8'hC5);
    n = 0;
    while (!(m_wr && m_addr == 16'hFE4D) && n < 1000) begin @(negedge clk); n++; end
    check("ar_reached_idx77", 32'(m_wr && m_addr == 16'hFE4D), 1);
    reset = 1'b1;
    #1;
    check("ar_m_rd", m_rd, 0);
    check("ar_m_wr", m_wr, 0);
    check("ar_m_addr", m_addr, 0);
    check("ar_m_wdata", m_wdata, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_logs();
    repeat (20) @(negedge clk);
    check("ar_quiet_reqs", req_seen, 0);
    check("ar_no_done", done_cnt, 0);
    cpu_read(16'hFF46);
    check("ar_page_cleared", cpu_rdata, 8'h00);
    check("ar_page_hit", cpu_hit, 1);

    check("bus_protocol_errs", bus_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
